// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared state type and sizing functions for apb_regfile
package apb_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

    function automatic int addr_lsb(input int dw);
        return (dw == 8) ? 0 : (dw == 16) ? 1 : 2;
    endfunction

    // Counter only ever holds (wait states - 1), so the larger count itself bounds the width.
    function automatic int ws_cnt_w(input int rd_ws, input int wr_ws);
        int m;
        int w;
        m = (rd_ws > wr_ws) ? rd_ws : wr_ws;
        w = 1;
        while ((1 << w) < m) w++;
        return w;
    endfunction

endpackage

// File: rtl/apb_addr_dec.sv
// rtl/apb_addr_dec.sv - register index, range check and access-permission decode
module apb_addr_dec
    import apb_pkg::*;
#(
    parameter int              DW      = 32,
    parameter int              AW      = 8,
    parameter int              N_REG   = 8,
    parameter logic [N_REG-1:0] RO_MASK = '0,
    parameter logic [N_REG-1:0] WO_MASK = '0,
    parameter int              IW      = AW - addr_lsb(DW)
) (
    input  logic [AW-1:0] paddr,
    input  logic          pwrite,
    output logic [IW-1:0] idx,
    output logic          is_ro,
    output logic          is_wo,
    output logic          err
);

    localparam int LSB = addr_lsb(DW);

    logic in_range;
    logic unused_addr;

    assign idx         = paddr[AW-1:LSB];
    assign unused_addr = ^paddr;

    // A register flagged both read-only and write-only behaves as read-only.
    always_comb begin
        in_range = 1'b0;
        is_ro    = 1'b0;
        is_wo    = 1'b0;
        for (int i = 0; i < N_REG; i++) begin
            if (idx == IW'(i)) begin
                in_range = 1'b1;
                is_ro    = RO_MASK[i];
                is_wo    = WO_MASK[i] & ~RO_MASK[i];
            end
        end
    end

    assign err = ~in_range | (pwrite & is_ro) | (~pwrite & is_wo);

endmodule

// File: rtl/apb_regfile.sv
// rtl/apb_regfile.sv - APB register file with wait states; APB_REGFILE_STRB_EN enables byte strobes
module apb_regfile
    import apb_pkg::*;
#(
    parameter int               DW      = 32,
    parameter int               AW      = 8,
    parameter int               N_REG   = 8,
    parameter int               RD_WS   = 1,
    parameter int               WR_WS   = 0,
    parameter logic [N_REG-1:0] RO_MASK = '0,
    parameter logic [N_REG-1:0] WO_MASK = '0
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic [AW-1:0]       i_paddr,
    input  logic                i_pwrite,
    input  logic                i_psel,
    input  logic                i_penable,
    input  logic [DW-1:0]       i_pwdata,
    input  logic [DW/8-1:0]     i_pstrb,
    output logic [DW-1:0]       o_prdata,
    output logic                o_pready,
    output logic                o_pslverr,
    output logic [N_REG*DW-1:0] o_hw_ctl,
    input  logic [N_REG*DW-1:0] i_hw_sts,
    output logic [N_REG-1:0]    o_wr_stb
);

    localparam int IW = AW - addr_lsb(DW);
    localparam int CW = ws_cnt_w(RD_WS, WR_WS);
    localparam int NB = DW / 8;
    localparam logic [CW-1:0] RD_INIT = CW'((RD_WS > 0) ? RD_WS - 1 : 0);
    localparam logic [CW-1:0] WR_INIT = CW'((WR_WS > 0) ? WR_WS - 1 : 0);

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [AW-1:0]   addr_q;
    logic            write_q;
    logic [DW-1:0]   regs [N_REG];
    logic            capture, load, commit;
    logic [AW-1:0]   dec_addr;
    logic            dec_write;
    logic [IW-1:0]   idx;
    logic            is_ro, is_wo, err;
    logic [DW-1:0]   rdata;
    logic [NB-1:0]   ben;

    // In IDLE the setup-cycle address is decoded directly so zero-wait transfers complete on time.
    assign dec_addr  = (state == IDLE) ? i_paddr  : addr_q;
    assign dec_write = (state == IDLE) ? i_pwrite : write_q;

    apb_addr_dec #(
        .DW      (DW),
        .AW      (AW),
        .N_REG   (N_REG),
        .RO_MASK (RO_MASK),
        .WO_MASK (WO_MASK),
        .IW      (IW)
    ) u_dec (
        .paddr  (dec_addr),
        .pwrite (dec_write),
        .idx    (idx),
        .is_ro  (is_ro),
        .is_wo  (is_wo),
        .err    (err)
    );

`ifdef APB_REGFILE_STRB_EN
    assign ben = i_pstrb;
`else
    logic unused_strb;
    assign ben         = '1;
    assign unused_strb = ^i_pstrb;
`endif

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        capture = 1'b0;
        load    = 1'b0;
        commit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_psel && !i_penable) begin
                    capture = 1'b1;
                    if ((i_pwrite ? WR_WS : RD_WS) == 0) begin
                        load    = 1'b1;
                        state_d = ACCESS;
                    end else begin
                        cnt_d   = i_pwrite ? WR_INIT : RD_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!i_psel) begin
                    state_d = IDLE;
                end else if (cnt == '0) begin
                    load    = 1'b1;
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            ACCESS: begin
                state_d = IDLE;
                commit  = i_psel && i_penable && write_q && !err;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_REG; i++) begin
            if (idx == IW'(i) && !is_wo) begin
                rdata = is_ro ? i_hw_sts[i*DW +: DW] : regs[i];
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            o_prdata  <= '0;
            o_pready  <= 1'b0;
            o_pslverr <= 1'b0;
            o_wr_stb  <= '0;
            for (int i = 0; i < N_REG; i++) regs[i] <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            o_pready  <= load;
            o_pslverr <= load & err;
            o_wr_stb  <= '0;
            if (capture) begin
                addr_q  <= i_paddr;
                write_q <= i_pwrite;
            end
            if (load && !dec_write) o_prdata <= rdata;
            if (commit) begin
                for (int i = 0; i < N_REG; i++) begin
                    if (idx == IW'(i)) begin
                        o_wr_stb[i] <= 1'b1;
                        for (int b = 0; b < NB; b++) begin
                            if (ben[b]) regs[i][b*8 +: 8] <= i_pwdata[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < N_REG; g++) begin : g_hw_ctl
        assign o_hw_ctl[g*DW +: DW] = regs[g];
    end

endmodule

// File: doc/apb_regfile.md
APB_REGFILE -- requirements
Module: apb_regfile

Interface
REQ-001 Parameter DW, default 32, data width; legal values 8, 16, 32.
REQ-002 Parameter AW, default 8, address width; at most 32.
REQ-003 Parameter N_REG, default 8, register count; at most 2**(AW-log2(DW/8)).
REQ-004 Parameter RD_WS, default 1, read wait states; range 0..15.
REQ-005 Parameter WR_WS, default 0, write wait states; range 0..15.
REQ-006 Parameter RO_MASK, default '0, N_REG bits; bit i=1 makes register i read-only, driven by i_hw_sts.
REQ-007 Parameter WO_MASK, default '0, N_REG bits; bit i=1 makes register i write-only.
REQ-008 pclk  in  1  clock; one clock; all logic on rising edge.
REQ-009 preset  in  1  reset; synchronous, active-high.
REQ-010 i_paddr in AW, i_pwrite in 1, i_psel in 1, i_penable in 1, i_pwdata in DW, i_pstrb in DW/8: APB requester inputs.
REQ-011 o_prdata out DW, o_pready out 1, o_pslverr out 1: APB completer outputs, all registered.
REQ-012 o_hw_ctl  out  N_REG*DW  flattened register contents; slice i = register i.
REQ-013 i_hw_sts  in  N_REG*DW  flattened HW status; slice i is read for RO registers.
REQ-014 o_wr_stb  out  N_REG  one-cycle pulse on each committed write to register i.

Function
REQ-015 Register index = i_paddr[AW-1:log2(DW/8)]; low byte-offset bits ignored.
REQ-016 FSM states: IDLE, WAIT, ACCESS.
REQ-017 IDLE, psel=1 and penable=0 (setup): latch address, direction, index; WS = RD_WS or WR_WS; WS=0 -> o_pready<=1, go ACCESS; else counter<=WS-1, go WAIT.
REQ-018 WAIT: counter=0 -> o_pready<=1, go ACCESS; else decrement.
REQ-019 WAIT with psel=0 (abort): o_pready<=0, o_pslverr<=0, go IDLE; no write, no o_wr_stb.
REQ-020 ACCESS: lasts one cycle with o_pready=1; write commits if psel=1 and penable=1; next cycle o_pready<=0, o_pslverr<=0, state IDLE.
REQ-021 Latency from setup cycle to completing cycle: WS+1 cycles; back-to-back transfers accepted with a setup cycle directly after ACCESS.
REQ-022 o_prdata and o_pslverr are loaded in the same cycle o_pready is set; o_prdata is held until the next read load.
REQ-023 Read data: RW register returns its value; RO register returns the i_hw_sts slice sampled on the load cycle; WO register or index>=N_REG returns 0.
REQ-024 o_pslverr=1 on: write to RO; read of WO; any access with index>=N_REG. An errored write changes no state.
REQ-025 Register with both RO_MASK and WO_MASK bits set is treated as RO.
REQ-026 Committed write updates only bytes enabled per REQ-036/037 and pulses o_wr_stb[i] in the cycle after commit.

Reset
REQ-027 preset=1 at a clock edge: state IDLE, counter 0, all registers 0, o_prdata 0, o_pready 0, o_pslverr 0, o_wr_stb 0.
REQ-028 Reset during WAIT or ACCESS aborts the transfer; the pending write is not committed.
REQ-029 Reset has priority over all other behaviour.

Configuration
REQ-030 Macro APB_REGFILE_STRB_EN selects byte-strobe handling.
REQ-031 Defined: byte k of the register written only when i_pstrb[k]=1; a write with i_pstrb=0 commits nothing but still pulses o_wr_stb.
REQ-032 Undefined: i_pstrb ignored; every committed write updates the full word.

Structure
REQ-033 Package apb_pkg holds state_t enum (IDLE, WAIT, ACCESS) and the ADDR_LSB and ws-counter-width constant functions.
REQ-034 One sub-module apb_addr_dec: combinational index, range check, RO/WO decode, error flag.
REQ-035 FSM, wait counter, register array and read mux reside in apb_regfile.
REQ-036 With the strobe macro defined, byte write enable = i_pstrb.
REQ-037 With the strobe macro undefined, byte write enable = all ones.

Verification
REQ-038 DW=32, WR_WS=0: write 0xA5A5_1234 to 0x04 -> pready high in access cycle, reg1=0xA5A5_1234, o_wr_stb[1] pulses once.
REQ-039 RD_WS=3: read 0x04 -> pready asserted 4 cycles after setup, o_prdata=0xA5A5_1234, pslverr=0.
REQ-040 RO_MASK=8'h08, i_hw_sts slice3=0xDEAD_BEEF: write 0x0C -> pslverr=1, no change; read 0x0C -> 0xDEAD_BEEF.
REQ-041 N_REG=8: read 0x40 -> pslverr=1, prdata=0; WO_MASK=8'h02, read 0x04 -> pslverr=1, prdata=0.
REQ-042 STRB_EN defined: reg2=0xFFFF_FFFF, write 0x0 with pstrb=4'b0101 -> reg2=0xFF00_FF00; macro undefined -> reg2=0.
REQ-043 Drop psel in WAIT, or assert preset in WAIT, during write of 0x55 -> register unchanged, no strobe, FSM returns to IDLE.
